// File: rtl/wb_pwm_slave_pkg.sv
// Shared bus constants: peripheral base addresses, PWM register offsets and CTRL bit positions.
// The bus decoder and every slave take their address map from here.
package wb_pwm_slave_pkg;

  localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
  localparam logic [31:0] GPIO_IN_BASE  = 32'h0000_0100;
  localparam logic [31:0] GPIO_OUT_BASE = 32'h0000_0200;
  localparam logic [31:0] PWM_BASE      = 32'h0000_0300;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_DUTY   = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_POLARITY = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_W        = 3;

  localparam int PWM_W = 16;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_pwm_slave_core.sv
// PWM engine: shadowed PERIOD/DUTY, free-running counter, compare and wrap pulse.
// The register file only ever talks to the programmed values; the waveform sees the shadows.
module pwm_core
  import wb_pwm_slave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             polarity,
  input  logic [PWM_W-1:0] period,
  input  logic [PWM_W-1:0] duty,
  output logic [PWM_W-1:0] count,
  output logic             wrap,
  output logic             pwm_out
);

  logic [PWM_W-1:0] count_q, count_d;
  logic [PWM_W-1:0] sh_period_q, sh_period_d;
  logic [PWM_W-1:0] sh_duty_q, sh_duty_d;
  logic             pwm_q, pwm_d;
  logic             running;

  assign running = enable & (sh_period_q != '0);
  assign wrap    = running & (count_q == (sh_period_q - 16'd1));

  always_comb begin
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    // Shadows take the pre-edge programmed values, so a same-edge write waits a full period.
    if (!enable || wrap) begin
      sh_period_d = period;
      sh_duty_d   = duty;
    end
    count_d = (running && !wrap) ? count_q + 16'd1 : '0;
    pwm_d   = (running && (count_q < sh_duty_q)) ^ polarity;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      pwm_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign count   = count_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/wb_pwm_slave.sv
// Wishbone register file for the PWM peripheral: one wait state, registered ACK and read data.
module wb_pwm_slave
  import wb_pwm_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PWM_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        pwm_out,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PWM_W-1:0]  period_q, period_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic              wrap_flag_q, wrap_flag_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              hit;
  logic              wr_en;
  logic [7:0]        off;
  logic [31:0]       rd_val;
  logic [31:0]       merged;
  logic [PWM_W-1:0]  count;
  logic              wrap_pulse;

  assign off   = ADR_I[7:0];
  // Masking with ack_q stops a master still holding STB in wait-ack from getting a second ACK.
  assign hit   = CYC_I & STB_I & (ADR_I[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr_en = hit & WE_I;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:   rd_val[CTRL_W-1:0] = ctrl_q;
      OFF_PERIOD: rd_val[PWM_W-1:0]  = period_q;
      OFF_DUTY:   rd_val[PWM_W-1:0]  = duty_q;
      OFF_COUNT:  rd_val[PWM_W-1:0]  = count;
      OFF_STATUS: rd_val[0]          = wrap_flag_q;
      default:    rd_val             = '0;
    endcase
  end

  always_comb begin
    merged      = byte_merge(rd_val, DAT_I, SEL_I);
    ctrl_d      = ctrl_q;
    period_d    = period_q;
    duty_d      = duty_q;
    wrap_flag_d = wrap_flag_q;
    if (wr_en) begin
      case (off)
        OFF_CTRL:   ctrl_d   = merged[CTRL_W-1:0];
        OFF_PERIOD: period_d = merged[PWM_W-1:0];
        OFF_DUTY:   duty_d   = merged[PWM_W-1:0];
        OFF_STATUS: if (SEL_I[0] && DAT_I[0]) wrap_flag_d = 1'b0;
        default:    ;
      endcase
    end
    if (wrap_pulse) wrap_flag_d = 1'b1;
    ack_d = hit;
    dat_d = hit ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      wrap_flag_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      wrap_flag_q <= wrap_flag_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  pwm_core u_core (
    .clk      (clk),
    .reset    (reset),
    .enable   (ctrl_q[CTRL_ENABLE]),
    .polarity (ctrl_q[CTRL_POLARITY]),
    .period   (period_q),
    .duty     (duty_q),
    .count    (count),
    .wrap     (wrap_pulse),
    .pwm_out  (pwm_out)
  );

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign irq   = wrap_flag_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_wb_pwm_slave.sv
// Randomized bench for wb_pwm_slave: a behavioural model of the register map and waveform
// predicts ACK_O/DAT_O/pwm_out/irq every cycle; directed phases cover the listed corner cases.
module tb_wb_pwm_slave;

  logic        clk;
  logic        reset;
  logic        CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_O;
  logic        ACK_O, pwm_out, irq;

  wb_pwm_slave dut (
    .clk(clk), .reset(reset), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .pwm_out(pwm_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: peripheral state as seen by software, stepped once per rising edge.
  logic [2:0]  m_ctrl;
  logic [15:0] m_period, m_duty, m_sp, m_sd, m_cnt;
  logic        m_wrapst, m_ack, m_pwm;
  logic [31:0] m_dat;

  always @(posedge clk) begin
    logic hit, en, running, wrap;
    logic [31:0] rd, wv;
    if (reset) begin
      m_ctrl <= '0; m_period <= '0; m_duty <= '0; m_sp <= '0; m_sd <= '0; m_cnt <= '0;
      m_wrapst <= 1'b0; m_ack <= 1'b0; m_pwm <= 1'b0; m_dat <= '0;
    end else begin
      en      = m_ctrl[0];
      hit     = CYC_I && STB_I && (ADR_I[31:8] == 24'h000003) && !m_ack;
      running = en && (m_sp != 16'd0);
      wrap    = running && (m_cnt == m_sp - 16'd1);
      case (ADR_I[7:0])
        8'h00:   rd = {29'd0, m_ctrl};
        8'h04:   rd = {16'd0, m_period};
        8'h08:   rd = {16'd0, m_duty};
        8'h0C:   rd = {16'd0, m_cnt};
        8'h10:   rd = {31'd0, m_wrapst};
        default: rd = 32'd0;
      endcase
      m_ack <= hit;
      m_dat <= hit ? rd : 32'd0;
      m_pwm <= (running && (m_cnt < m_sd)) ^ m_ctrl[1];
      m_cnt <= (running && !wrap) ? m_cnt + 16'd1 : 16'd0;
      if (!en || wrap) begin
        m_sp <= m_period;
        m_sd <= m_duty;
      end
      if (wrap) m_wrapst <= 1'b1;
      else if (hit && WE_I && ADR_I[7:0] == 8'h10 && SEL_I[0] && DAT_I[0]) m_wrapst <= 1'b0;
      if (hit && WE_I) begin
        wv = rd;
        for (int b = 0; b < 4; b++) if (SEL_I[b]) wv[8*b +: 8] = DAT_I[8*b +: 8];
        case (ADR_I[7:0])
          8'h00: m_ctrl   <= wv[2:0];
          8'h04: m_period <= wv[15:0];
          8'h08: m_duty   <= wv[15:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("ack", {31'd0, ACK_O}, {31'd0, m_ack});
      check_val("dat", DAT_O, m_dat);
      check_val("pwm", {31'd0, pwm_out}, {31'd0, m_pwm});
      check_val("irq", {31'd0, irq}, {31'd0, m_wrapst & m_ctrl[2]});
    end
  end

  // Caller is at a falling edge; returns at a falling edge with the bus idle.
  task automatic wb_xfer(input logic [31:0] addr, input logic [31:0] data, input logic we,
                         input logic [3:0] sel, input int hold, output logic [31:0] rdata,
                         output logic acked, output int lat, output int nack);
    acked = 1'b0; rdata = '0; lat = 0; nack = 0;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = addr; DAT_I = data; SEL_I = sel;
    for (int n = 1; n <= 8 && !acked; n++) begin
      @(negedge clk);
      if (ACK_O) begin acked = 1'b1; rdata = DAT_O; lat = n; nack = 1; end
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (ACK_O) nack++;
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; SEL_I = 4'h0;
    $display("xfer %s adr=%08h dat=%08h sel=%h ack=%0d lat=%0d rd=%08h",
             we ? "W" : "R", addr, data, sel, acked, lat, rdata);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic ak; int lat, nk;
    wb_xfer(addr, data, 1'b1, 4'hF, 0, rd, ak, lat, nk);
    check_val("wr_ack_lat", lat, 1);
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    logic ak; int lat, nk;
    wb_xfer(addr, 32'd0, 1'b0, 4'hF, 0, data, ak, lat, nk);
    check_val("rd_ack_lat", lat, 1);
    @(negedge clk);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out) c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] v, input string tag);
    int g;
    g = 0;
    while (m_cnt != v && g < 100) begin @(negedge clk); g++; end
    check_val(tag, {31'd0, g < 100}, 32'd1);
  endtask

  logic [7:0] offs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFC};

  initial begin
    logic [31:0] rd, a, d, t;
    logic ak;
    int lat, nk, c, g;
    reset = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = '0; DAT_I = '0; SEL_I = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_val("rst_ack", {31'd0, ACK_O}, 32'd0);
    check_val("rst_dat", DAT_O, 32'd0);
    check_val("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // Basic 3-of-10 waveform.
    wb_write(32'h304, 32'd10);
    wb_write(32'h308, 32'd3);
    wb_write(32'h300, 32'h1);
    repeat (15) @(negedge clk);
    count_high(30, c);
    check_val("high_3of10", c, 9);
    for (int i = 0; i < 3; i++) begin
      wb_read(32'h30C, rd);
      check_val("count_range", {31'd0, rd < 32'd10}, 32'd1);
      repeat (i + 2) @(negedge clk);
    end

    // STB held through the wait-ack cycle: single ACK with PERIOD.
    wb_xfer(32'h304, 32'd0, 1'b0, 4'hF, 1, rd, ak, lat, nk);
    check_val("hold_nack", nk, 1);
    check_val("hold_data", rd, 32'h0000_000A);
    @(negedge clk);

    // CYC without STB must not ACK.
    CYC_I = 1'b1; ADR_I = 32'h304;
    repeat (3) @(negedge clk);
    CYC_I = 1'b0;

    // Mid-period duty change takes effect the following period.
    wait_cnt(16'd4, "wait_mid");
    wb_write(32'h308, 32'd7);
    wait_cnt(16'd1, "wait_next");
    count_high(10, c);
    check_val("duty7_period", c, 7);

    // Duty beyond period, then polarity, then PERIOD=0.
    wb_write(32'h308, 32'd12);
    wait_cnt(16'd1, "wait_d12");
    count_high(20, c);
    check_val("duty12_high", c, 20);
    wb_write(32'h300, 32'h3);
    repeat (2) @(negedge clk);
    count_high(20, c);
    check_val("pol_high", c, 0);
    wb_write(32'h304, 32'd0);
    g = 0;
    while (m_sp != 16'd0 && g < 40) begin @(negedge clk); g++; end
    wb_write(32'h310, 32'h1);
    wb_read(32'h30C, rd);
    check_val("p0_count", rd, 32'd0);
    repeat (20) @(negedge clk);
    wb_read(32'h310, rd);
    check_val("p0_nowrap", rd, 32'd0);

    // Interrupt, clear racing a wrap (set wins), then a clean clear.
    wb_write(32'h300, 32'h0);
    wb_write(32'h304, 32'd10);
    wb_write(32'h308, 32'd3);
    wb_write(32'h300, 32'h5);
    g = 0;
    while (!irq && g < 40) begin @(negedge clk); g++; end
    check_val("irq_set", {31'd0, irq}, 32'd1);
    wait_cnt(16'd9, "wait_wrap");
    wb_xfer(32'h310, 32'h1, 1'b1, 4'hF, 0, rd, ak, lat, nk);
    check_val("race_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    wb_read(32'h310, rd);
    check_val("race_status", rd, 32'd1);
    wait_cnt(16'd2, "wait_clr");
    wb_xfer(32'h310, 32'h1, 1'b1, 4'hF, 0, rd, ak, lat, nk);
    check_val("irq_clr", {31'd0, irq}, 32'd0);
    @(negedge clk);

    // Out-of-window access and a no-byte-lane write.
    wb_xfer(32'h404, 32'd0, 1'b0, 4'hF, 0, rd, ak, lat, nk);
    check_val("oow_noack", {31'd0, ak}, 32'd0);
    @(negedge clk);
    wb_xfer(32'h3FC, 32'hFFFF_FFFF, 1'b1, 4'h0, 0, rd, ak, lat, nk);
    check_val("sel0_ack", {31'd0, ak}, 32'd1);
    @(negedge clk);
    wb_read(32'h304, rd);
    check_val("sel0_period", rd, {16'd0, m_period});
    wb_read(32'h300, rd);
    check_val("sel0_ctrl", rd, {29'd0, m_ctrl});

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      logic out;
      out = ($urandom_range(0, 19) == 0);
      a = out ? (($urandom_range(0, 1) == 0) ? 32'h404 : 32'h200)
              : (32'h300 | {24'd0, offs[$urandom_range(0, 6)]});
      t = $urandom;
      d = (a[7:0] == 8'h04 || a[7:0] == 8'h08) ? {t[31:16], 16'($urandom_range(0, 12))} : t;
      wb_xfer(a, d, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
              $urandom_range(0, 2), rd, ak, lat, nk);
      check_val("rnd_ack", {31'd0, ak}, {31'd0, !out});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);

    // Reset in the ACK cycle, and reset on the hit edge discarding a write.
    wb_write(32'h308, 32'd5);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h304; DAT_I = 32'd7; SEL_I = 4'hF;
    @(negedge clk);
    check_val("pre_rst_ack", {31'd0, ACK_O}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("midack_ack", {31'd0, ACK_O}, 32'd0);
    check_val("midack_dat", DAT_O, 32'd0);
    check_val("midack_pwm", {31'd0, pwm_out}, 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    reset = 1'b0;
    wb_write(32'h304, 32'd6);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h308; DAT_I = 32'd9;
    reset = 1'b1;
    @(negedge clk);
    check_val("disc_ack", {31'd0, ACK_O}, 32'd0);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_read(32'h300 | {24'd0, offs[i]}, rd);
      check_val("post_rst_reg", rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
